// File: rtl/instr_decode_reg.sv
// Instruction register and one-hot decoder that feeds the control FSM, with a stall-and-timeout fetch handshake.
// Optional build macro ILLEGAL_TRAP_EN adds an `illegal` flag for undefined SHIFT subcodes.
module instr_decode_reg #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ir_load,
  input  logic [15:0] imem_data,
  input  logic        imem_valid,
  output logic        imem_req,
  output logic [26:0] opcode_out,
  output logic [7:0]  imm_out,
  output logic        ir_valid,
  output logic        busy,
  output logic        fetch_timeout
`ifdef ILLEGAL_TRAP_EN
  ,
  output logic        illegal
`endif
);

  localparam logic [26:0] NOOP_WORD = 27'h0000001;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             capture, timeout;

  // Bit numbers follow the order of the instruction set listing; undefined SHIFT subcodes map to NOOP.
  function automatic logic [22:0] decode_onehot(input logic [15:0] w);
    logic [4:0] idx;
    idx = 5'd0;
    case (w[15:12])
      4'h0:    idx = 5'd0;
      4'h1:    idx = 5'd1 + {3'b000, w[9:8]};
      4'hC:    idx = w[9] ? 5'd0 : (5'd15 + {4'b0000, w[8]});
      4'hD:    idx = 5'd17;
      4'hE:    idx = 5'd18;
      4'hF:    idx = 5'd19 + {3'b000, w[9:8]};
      default: idx = {1'b0, w[15:12]} + 5'd3;
    endcase
    return 23'd1 << idx;
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      S_IDLE: begin
        if (ir_load) begin
          if (imem_valid) begin
            capture = 1'b1;
          end else begin
            state_next = S_WAIT;
            cnt_next   = '0;
          end
        end
      end
      S_WAIT: begin
        // A word arriving on the expiry cycle still counts as a successful fetch.
        if (imem_valid) begin
          capture    = 1'b1;
          state_next = S_IDLE;
        end else if (cnt == CNT_W'(MAX_WAIT - 1)) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign imem_req = (state == S_WAIT) || ((state == S_IDLE) && ir_load);
  assign busy     = (state == S_WAIT);

  always_ff @(posedge clock) begin
    if (reset) begin
      opcode_out    <= NOOP_WORD;
      imm_out       <= 8'h00;
      ir_valid      <= 1'b0;
      fetch_timeout <= 1'b0;
    end else begin
      fetch_timeout <= timeout;
      if (capture) begin
        opcode_out <= {imem_data[11:10], imem_data[9:8], decode_onehot(imem_data)};
        imm_out    <= imem_data[7:0];
        ir_valid   <= 1'b1;
      end else if (timeout) begin
        opcode_out <= NOOP_WORD;
        imm_out    <= 8'h00;
        ir_valid   <= 1'b1;
      end
    end
  end

`ifdef ILLEGAL_TRAP_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal <= 1'b0;
    end else if (capture) begin
      illegal <= (imem_data[15:12] == 4'hC) && imem_data[9];
    end
  end
`endif

endmodule

// File: tb/tb_instr_decode_reg.sv
// Self-checking bench for instr_decode_reg: constant decode table, hand-written stall/timeout/reset
// sequences, a full opcode sweep and randomized traffic, all compared against a cycle-level reference model.
module tb_instr_decode_reg;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 8;
  localparam logic [26:0] NOOP_WORD = 27'h0000001;

  logic        clock;
  logic        reset;
  logic        ir_load;
  logic [15:0] imem_data;
  logic        imem_valid;
  logic        imem_req;
  logic [26:0] opcode_out;
  logic [7:0]  imm_out;
  logic        ir_valid;
  logic        busy;
  logic        fetch_timeout;
`ifdef ILLEGAL_TRAP_EN
  logic        illegal;
`endif

  instr_decode_reg #(
    .MAX_WAIT(MAX_WAIT),
    .CNT_W   (CNT_W)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .ir_load      (ir_load),
    .imem_data    (imem_data),
    .imem_valid   (imem_valid),
    .imem_req     (imem_req),
    .opcode_out   (opcode_out),
    .imm_out      (imm_out),
    .ir_valid     (ir_valid),
    .busy         (busy),
    .fetch_timeout(fetch_timeout)
`ifdef ILLEGAL_TRAP_EN
    ,
    .illegal      (illegal)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state: a fetch is either pending or not, with the number of cycles waited so far.
  int          bit_of[64];
  bit          m_pending;
  int          m_waited;
  logic [26:0] m_op;
  logic [7:0]  m_imm;
  bit          m_valid;
  bit          m_timeout;
  bit          m_illegal;

  typedef struct {
    logic [15:0] word;
    int          bit_idx;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One-hot bits are handed out in listing order; SHIFT only owns two of its four subcodes.
  task automatic init_table();
    int next_bit;
    next_bit = 0;
    for (int op = 0; op < 16; op++) begin
      if (op == 1 || op == 15) begin
        for (int s = 0; s < 4; s++) begin
          bit_of[op*4+s] = next_bit;
          next_bit = next_bit + 1;
        end
      end else if (op == 12) begin
        bit_of[48] = next_bit;
        bit_of[49] = next_bit + 1;
        bit_of[50] = 0;
        bit_of[51] = 0;
        next_bit = next_bit + 2;
      end else begin
        for (int s = 0; s < 4; s++) bit_of[op*4+s] = next_bit;
        next_bit = next_bit + 1;
      end
    end
  endtask

  function automatic logic [26:0] model_decode(input logic [15:0] w);
    logic [22:0] oh;
    oh = '0;
    oh[bit_of[{w[15:12], w[9:8]}]] = 1'b1;
    return {w[11:10], w[9:8], oh};
  endfunction

  task automatic model_capture(input logic [15:0] d);
    m_op      = model_decode(d);
    m_imm     = d[7:0];
    m_valid   = 1'b1;
    m_illegal = (d[15:12] == 4'hC) && d[9];
  endtask

  task automatic model_step(input logic rst, input logic ld, input logic vld, input logic [15:0] d);
    m_timeout = 1'b0;
    if (rst) begin
      m_pending = 1'b0;
      m_waited  = 0;
      m_op      = NOOP_WORD;
      m_imm     = 8'h00;
      m_valid   = 1'b0;
      m_illegal = 1'b0;
    end else if (m_pending) begin
      m_waited = m_waited + 1;
      if (vld) begin
        model_capture(d);
        m_pending = 1'b0;
      end else if (m_waited == MAX_WAIT) begin
        m_op      = NOOP_WORD;
        m_imm     = 8'h00;
        m_valid   = 1'b1;
        m_timeout = 1'b1;
        m_pending = 1'b0;
      end
    end else if (ld) begin
      if (vld) model_capture(d);
      else begin
        m_pending = 1'b1;
        m_waited  = 0;
      end
    end
  endtask

  task automatic check_output();
    check("opcode_out", 32'(opcode_out), 32'(m_op));
    check("imm_out", 32'(imm_out), 32'(m_imm));
    check("ir_valid", 32'(ir_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_pending));
    check("fetch_timeout", 32'(fetch_timeout), 32'(m_timeout));
`ifdef ILLEGAL_TRAP_EN
    check("illegal", 32'(illegal), 32'(m_illegal));
`endif
  endtask

  // Called just after a rising edge: drive, check the combinational request, clock, then check registers.
  task automatic apply_stimulus(input logic rst, input logic ld, input logic vld, input logic [15:0] d);
    reset      = rst;
    ir_load    = ld;
    imem_valid = vld;
    imem_data  = d;
    #1;
    check("imem_req", 32'(imem_req), 32'(m_pending || ld));
    @(posedge clock);
    model_step(rst, ld, vld, d);
    #1;
    check_output();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [22:0] oh;
    logic [15:0] w;
    int pulses;
    int pulse_at;

    init_table();
    vecs[0]  = '{16'h4600, 7};
    vecs[1]  = '{16'hF2A5, 21};
    vecs[2]  = '{16'h0000, 0};
    vecs[3]  = '{16'h1300, 4};
    vecs[4]  = '{16'h1155, 2};
    vecs[5]  = '{16'h2000, 5};
    vecs[6]  = '{16'hB3C4, 14};
    vecs[7]  = '{16'hC0FF, 15};
    vecs[8]  = '{16'hC100, 16};
    vecs[9]  = '{16'hC2AA, 0};
    vecs[10] = '{16'hD012, 17};
    vecs[11] = '{16'hE7E7, 18};
    vecs[12] = '{16'hFF01, 22};

    reset = 1'b1; ir_load = 1'b0; imem_valid = 1'b0; imem_data = 16'h0000;
    @(posedge clock);
    #1;
    model_step(1'b1, 1'b0, 1'b0, 16'h0000);

    $display("[TB] reset state");
    repeat (3) apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    check("rst_opcode", 32'(opcode_out), 32'(NOOP_WORD));
    check("rst_imm", 32'(imm_out), 32'h0);
    check("rst_ir_valid", 32'(ir_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);

    $display("[TB] decode table");
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(1'b0, 1'b1, 1'b1, vecs[i].word);
      oh = '0;
      oh[vecs[i].bit_idx] = 1'b1;
      w = vecs[i].word;
      check("tbl_opcode", 32'(opcode_out), 32'({w[11:10], w[9:8], oh}));
      check("tbl_imm", 32'(imm_out), 32'(w[7:0]));
      check("tbl_ir_valid", 32'(ir_valid), 32'h1);
    end

    $display("[TB] stalled fetch");
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h1234);
    check("stall_busy0", 32'(busy), 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    check("stall_busy1", 32'(busy), 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    check("stall_busy2", 32'(busy), 32'h1);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'hF2A5);
    check("stall_bit21", 32'(opcode_out[21]), 32'h1);
    check("stall_imm", 32'(imm_out), 32'hA5);
    check("stall_busy_done", 32'(busy), 32'h0);

    $display("[TB] fetch timeout");
    pulses = 0;
    pulse_at = -1;
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
      if (fetch_timeout === 1'b1) begin
        pulses++;
        pulse_at = i;
      end
    end
    check("to_pulse_count", 32'(pulses), 32'd1);
    check("to_pulse_cycle", 32'(pulse_at), 32'(MAX_WAIT - 1));
    check("to_opcode", 32'(opcode_out), 32'(NOOP_WORD));
    check("to_busy", 32'(busy), 32'h0);

    $display("[TB] capture on expiry cycle");
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    repeat (MAX_WAIT - 1) apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h7123);
    check("exp_no_timeout", 32'(fetch_timeout), 32'h0);
    check("exp_bit10", 32'(opcode_out[10]), 32'h1);
    check("exp_imm", 32'(imm_out), 32'h23);

    $display("[TB] ir_load during wait, stray valid");
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b1, 1'b1, 16'h8000);
    apply_stimulus(1'b0, 1'b0, 1'b0, 16'h0000);
    check("ignore_busy", 32'(busy), 32'h0);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'hDEAD);

    $display("[TB] reset during wait");
    apply_stimulus(1'b0, 1'b1, 1'b0, 16'h0000);
    apply_stimulus(1'b1, 1'b0, 1'b0, 16'h0000);
    apply_stimulus(1'b0, 1'b0, 1'b1, 16'h1000);
    check("rstw_opcode", 32'(opcode_out), 32'(NOOP_WORD));
    check("rstw_ir_valid", 32'(ir_valid), 32'h0);

    $display("[TB] opcode sweep");
    for (int op = 0; op < 16; op++) begin
      for (int s = 0; s < 4; s++) begin
        w = {4'(op), 2'($urandom), 2'(s), 8'($urandom)};
        apply_stimulus(1'b0, 1'b1, 1'b1, w);
        check("sweep_onehot", 32'($countones(opcode_out[22:0])), 32'd1);
      end
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 40) == 0),
                     ($urandom_range(0, 2) == 0),
                     ($urandom_range(0, 3) == 0),
                     16'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
